// File: rtl/rpm_display.sv
// Binary RPM value to three-digit BCD (shift-add-3), shown on a multiplexed
// active-low seven-segment display with leading-zero blanking.
module rpm_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_RPM,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  last_val, last_nx;
  logic [7:0]  bin_sr, bin_nx;
  logic [11:0] acc, acc_nx, acc_adj;
  logic [11:0] bcd_nx;
  logic [2:0]  iter, iter_nx;

  logic [CW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic          blank;
  logic [2:0]    an_nx;

  function automatic logic [11:0] add3(input logic [11:0] a);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = (a[4*i +: 4] >= 4'd5) ? a[4*i +: 4] + 4'd3 : a[4*i +: 4];
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign busy    = (state != IDLE);
  assign acc_adj = add3(acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_val <= '0;
      bin_sr   <= '0;
      acc      <= '0;
      iter     <= '0;
      bcd      <= '0;
    end else begin
      state    <= state_nx;
      last_val <= last_nx;
      bin_sr   <= bin_nx;
      acc      <= acc_nx;
      iter     <= iter_nx;
      bcd      <= bcd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last_val;
    bin_nx   = bin_sr;
    acc_nx   = acc;
    iter_nx  = iter;
    bcd_nx   = bcd;
    case (state)
      IDLE: begin
        // input is only looked at here, so changes mid-conversion wait their turn
        if (data_RPM != last_val) begin
          last_nx  = data_RPM;
          bin_nx   = data_RPM;
          acc_nx   = '0;
          iter_nx  = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        {acc_nx, bin_nx} = {acc_adj[10:0], bin_sr, 1'b0};
        iter_nx = iter + 3'd1;
        if (iter == 3'd7) state_nx = DONE;
      end
      DONE: begin
        bcd_nx   = acc;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // digit select with leading-zero blanking; units always lit
  always_comb begin
    digit = bcd[3:0];
    blank = 1'b0;
    an_nx = 3'b110;
    case (idx)
      2'd1: begin
        digit = bcd[7:4];
        blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        an_nx = 3'b101;
      end
      2'd2: begin
        digit = bcd[11:8];
        blank = (bcd[11:8] == 4'd0);
        an_nx = 3'b011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 3'b111;
      seg <= 7'h7F;
    end else begin
      an  <= an_nx;
      seg <= blank ? 7'h7F : seg7(digit);
    end
  end

endmodule

// File: tb/tb_rpm_display.sv
// Randomized and directed bench for rpm_display against a cycle-count reference
// model built from decimal arithmetic.
module tb_rpm_display;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_RPM;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  rpm_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .data_RPM(data_RPM),
    .seg(seg), .an(an), .bcd(bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  logic [6:0] seg_tab [0:9];
  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
  end

  // reference model: a conversion is a 9-edge delay from capture to result
  bit          m_init = 0;
  int          m_tick, m_left, m_val;
  logic [7:0]  m_last;
  logic [11:0] m_bcd;
  logic [6:0]  e_seg;
  logic [2:0]  e_an;

  always @(posedge clk) begin
    int pos, h, t, u, d;
    bit blank;
    if (reset) begin
      m_init = 1; m_tick = 0; m_left = 0; m_last = 0; m_bcd = 0;
      e_seg = 7'h7F; e_an = 3'b111;
    end else begin
      pos = (m_tick / R) % 3;
      h = m_bcd / 256; t = (m_bcd / 16) % 16; u = m_bcd % 16;
      case (pos)
        0: begin d = u; blank = 0;               e_an = 3'b110; end
        1: begin d = t; blank = (h == 0 && t == 0); e_an = 3'b101; end
        default: begin d = h; blank = (h == 0);  e_an = 3'b011; end
      endcase
      e_seg = blank ? 7'h7F : seg_tab[d];
      m_tick++;
      if (m_left == 0) begin
        if (data_RPM != m_last) begin
          m_last = data_RPM; m_val = data_RPM; m_left = 9;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_bcd = dec3(m_val);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("bcd",  32'(bcd),  32'(m_bcd));
      chk("an",   32'(an),   32'(e_an));
      chk("seg",  32'(seg),  32'(e_seg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin cyc(1); n++; end while (busy && n < 40);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic find_an(input logic [2:0] p, input logic [6:0] s, input string tag);
    int n = 0;
    while (an !== p && n < 20) begin cyc(1); n++; end
    chk({tag, "_an"}, 32'(an), 32'(p));
    chk(tag, 32'(seg), 32'(s));
  endtask

  initial begin
    int n, hold;
    reset = 1'b1; data_RPM = 8'd0;
    cyc(3);
    chk("rst_an", 32'(an), 32'h7);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    cyc(1);
    chk("zero_nobusy", 32'(busy), 32'h0);
    data_RPM = 8'd173;
    cyc(1);
    n = 0;
    while (busy && n < 20) begin n++; cyc(1); end
    chk("busy_len", 32'(n), 32'd9);
    chk("bcd173", 32'(bcd), 32'h173);

    data_RPM = 8'd255; wait_idle();
    chk("bcd255", 32'(bcd), 32'h255);
    cyc(2);
    find_an(3'b110, 7'h12, "u255");
    find_an(3'b101, 7'h12, "t255");
    find_an(3'b011, 7'h24, "h255");

    data_RPM = 8'd7; wait_idle();
    chk("bcd007", 32'(bcd), 32'h007);
    cyc(2);
    find_an(3'b011, 7'h7F, "h007");
    find_an(3'b110, 7'h78, "u007");
    find_an(3'b101, 7'h7F, "t007");

    data_RPM = 8'd100; wait_idle();
    chk("bcd100", 32'(bcd), 32'h100);
    cyc(2);
    find_an(3'b011, 7'h79, "h100");
    find_an(3'b110, 7'h40, "u100");
    find_an(3'b101, 7'h40, "t100");

    // change lands during SHIFT: picked up only after the first conversion
    data_RPM = 8'd50; cyc(1); cyc(2);
    data_RPM = 8'd99; wait_idle();
    chk("bcd050", 32'(bcd), 32'h050);
    wait_idle();
    chk("bcd099", 32'(bcd), 32'h099);

    // reset sampled at the 4th SHIFT edge
    data_RPM = 8'd200; cyc(1); cyc(3);
    reset = 1'b1; cyc(1);
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_an", 32'(an), 32'h7);
    chk("abort_seg", 32'(seg), 32'h7F);
    reset = 1'b0; wait_idle();
    chk("bcd200", 32'(bcd), 32'h200);

    for (int i = 0; i < 300; i++) begin
      data_RPM = 8'($urandom);
      reset = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 14);
      cyc(hold);
    end
    reset = 1'b0; wait_idle(); wait_idle();

    for (int v = 0; v < 256; v++) begin
      data_RPM = 8'(v);
      wait_idle();
      chk("sweep", 32'(bcd), 32'(dec3(v)));
    end

    cyc(2);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
